// File: rtl/decode_pkg.sv
// Shared definitions for the MIPS32 decode queue.
// Holds the opcode/funct encodings, the ALU and branch enumerations,
// the uop bundle passed from decode to issue, and the serialisation
// FSM state type.
package decode_pkg;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type function codes (inst[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Second ALU operand select
    localparam logic [1:0] SRC_REG   = 2'd0;  // rt register
    localparam logic [1:0] SRC_SHAMT = 2'd1;  // shift amount field
    localparam logic [1:0] SRC_IMM   = 2'd2;  // extended immediate

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_NOR  = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SLL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SRL  = 4'h8,
        ALU_SLT  = 4'h9,
        ALU_SLTU = 4'hA,
        ALU_LUI  = 4'hB,
        ALU_LINK = 4'hC,
        ALU_PASS = 4'hE
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_J    = 3'd1,
        BR_JAL  = 3'd2,
        BR_JR   = 3'd3,
        BR_BEQ  = 3'd4,
        BR_BNE  = 3'd5,
        BR_BGEZ = 3'd6,
        BR_BLTZ = 3'd7
    } branch_type_e;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  pc_plus_4;
        logic [31:0]  jump_addr;
        logic [31:0]  br_target;
        logic [31:0]  imm;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   dst;
        logic [4:0]   shamt;
        alu_op_e      alu_ctrl;
        logic [1:0]   alu_src;
        logic         reg_write;
        logic         mem_to_reg;
        logic         mem_write;
        logic         mem_access;
        logic         branch;
        branch_type_e branch_type;
        logic         illegal;
    } uop_t;

    localparam int UOP_W = $bits(uop_t);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BR_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    // Sign-extend a 16-bit immediate to 32 bits
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational MIPS32 decoder: instruction word + pc -> uop_t.
// Unrecognised encodings produce a uop with illegal=1 and every
// write/memory/branch enable cleared, so downstream treats it as inert.
// Ports:
//   inst_i  32     instruction word
//   pc_i    32     instruction address
//   uop_o   uop_t  decoded micro-op
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output uop_t        uop_o
);

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [31:0] sext_imm_s;
    logic [31:0] pc_plus_4_s;

    assign op_s        = inst_i[31:26];
    assign rs_s        = inst_i[25:21];
    assign rt_s        = inst_i[20:16];
    assign rd_s        = inst_i[15:11];
    assign funct_s     = inst_i[5:0];
    assign sext_imm_s  = sext16(inst_i[15:0]);
    assign pc_plus_4_s = pc_i + 32'd4;

    logic [4:0] dst_sel_s;
    logic       legal_s;

    // Field extraction and per-opcode control decode
    always_comb begin
        uop_o             = '0;
        uop_o.pc          = pc_i;
        uop_o.pc_plus_4   = pc_plus_4_s;
        uop_o.jump_addr   = {pc_i[31:28], inst_i[25:0], 2'b00};
        // Branch offset always uses the sign-extended field, even for
        // opcodes whose imm is zero-extended.
        uop_o.br_target   = pc_plus_4_s + {sext_imm_s[29:0], 2'b00};
        uop_o.imm         = sext_imm_s;
        uop_o.rs          = rs_s;
        uop_o.rt          = rt_s;
        uop_o.shamt       = inst_i[10:6];
        uop_o.alu_ctrl    = ALU_ADD;
        uop_o.alu_src     = SRC_REG;
        uop_o.branch_type = BR_NONE;
        dst_sel_s         = rt_s;
        legal_s           = 1'b1;

        case (op_s)
            OP_RTYPE: begin
                dst_sel_s       = rd_s;
                uop_o.reg_write = 1'b1;
                case (funct_s)
                    FN_ADD, FN_ADDU: uop_o.alu_ctrl = ALU_ADD;
                    FN_SUBU:         uop_o.alu_ctrl = ALU_SUB;
                    FN_AND:          uop_o.alu_ctrl = ALU_AND;
                    FN_OR:           uop_o.alu_ctrl = ALU_OR;
                    FN_NOR:          uop_o.alu_ctrl = ALU_NOR;
                    FN_XOR:          uop_o.alu_ctrl = ALU_XOR;
                    FN_SLT:          uop_o.alu_ctrl = ALU_SLT;
                    FN_SLTU:         uop_o.alu_ctrl = ALU_SLTU;
                    FN_SLL: begin
                        // SLL to $0 is the canonical NOP: leave it as a
                        // non-writing ADD so it never touches the rename map.
                        if (rd_s == 5'd0) begin
                            uop_o.reg_write = 1'b0;
                            uop_o.alu_ctrl  = ALU_ADD;
                        end else begin
                            uop_o.alu_ctrl  = ALU_SLL;
                            uop_o.alu_src   = SRC_SHAMT;
                        end
                    end
                    FN_SRA: begin
                        uop_o.alu_ctrl = ALU_SRA;
                        uop_o.alu_src  = SRC_SHAMT;
                    end
                    FN_SRL: begin
                        uop_o.alu_ctrl = ALU_SRL;
                        uop_o.alu_src  = SRC_SHAMT;
                    end
                    FN_JR: begin
                        uop_o.reg_write   = 1'b0;
                        uop_o.alu_ctrl    = ALU_PASS;
                        uop_o.branch      = 1'b1;
                        uop_o.branch_type = BR_JR;
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                uop_o.reg_write = 1'b1;
                uop_o.alu_src   = SRC_IMM;
                if (op_s == OP_ADDIU) begin
                    uop_o.alu_ctrl = ALU_ADD;
                end else if (op_s == OP_SLTI) begin
                    uop_o.alu_ctrl = ALU_SLT;
                end else begin
                    uop_o.alu_ctrl = ALU_SLTU;
                end
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                uop_o.reg_write = 1'b1;
                uop_o.alu_src   = SRC_IMM;
                uop_o.imm       = {16'h0000, inst_i[15:0]};
                if (op_s == OP_ANDI) begin
                    uop_o.alu_ctrl = ALU_AND;
                end else if (op_s == OP_ORI) begin
                    uop_o.alu_ctrl = ALU_OR;
                end else begin
                    uop_o.alu_ctrl = ALU_XOR;
                end
            end
            OP_LUI: begin
                uop_o.reg_write = 1'b1;
                uop_o.alu_src   = SRC_IMM;
                uop_o.alu_ctrl  = ALU_LUI;
                uop_o.imm       = {inst_i[15:0], 16'h0000};
            end
            OP_BEQ, OP_BNE: begin
                uop_o.alu_ctrl    = ALU_SUB;
                uop_o.branch      = 1'b1;
                if (op_s == OP_BEQ) begin
                    uop_o.branch_type = BR_BEQ;
                end else begin
                    uop_o.branch_type = BR_BNE;
                end
            end
            OP_REGIMM: begin
                // Only rt==1 selects BGEZ; every other rt is treated as BLTZ.
                uop_o.alu_ctrl = ALU_PASS;
                uop_o.branch   = 1'b1;
                if (rt_s == 5'd1) begin
                    uop_o.branch_type = BR_BGEZ;
                end else begin
                    uop_o.branch_type = BR_BLTZ;
                end
            end
            OP_LW: begin
                uop_o.reg_write  = 1'b1;
                uop_o.mem_to_reg = 1'b1;
                uop_o.mem_access = 1'b1;
                uop_o.alu_src    = SRC_IMM;
            end
            OP_SW: begin
                uop_o.mem_write  = 1'b1;
                uop_o.mem_access = 1'b1;
                uop_o.alu_src    = SRC_IMM;
            end
            OP_J: begin
                uop_o.alu_ctrl    = ALU_PASS;
                uop_o.branch      = 1'b1;
                uop_o.branch_type = BR_J;
            end
            OP_JAL: begin
                uop_o.reg_write   = 1'b1;
                uop_o.alu_ctrl    = ALU_LINK;
                uop_o.branch      = 1'b1;
                uop_o.branch_type = BR_JAL;
                dst_sel_s         = 5'd31;
            end
            default: legal_s = 1'b0;
        endcase

        if (legal_s) begin
            uop_o.illegal = 1'b0;
        end else begin
            uop_o.illegal     = 1'b1;
            uop_o.reg_write   = 1'b0;
            uop_o.mem_to_reg  = 1'b0;
            uop_o.mem_write   = 1'b0;
            uop_o.mem_access  = 1'b0;
            uop_o.branch      = 1'b0;
            uop_o.branch_type = BR_NONE;
            uop_o.alu_ctrl    = ALU_ADD;
            uop_o.alu_src     = SRC_REG;
        end

        // A non-writing uop carries dst=0 so rename never allocates for it
        if (uop_o.reg_write) begin
            uop_o.dst = dst_sel_s;
        end else begin
            uop_o.dst = 5'd0;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// MIPS32 decode stage for the out-of-order front end.
// Accepts (inst, pc) from fetch on a valid/ready handshake, decodes via
// decode_comb, and buffers up to DEPTH uops in a FIFO. Control-flow
// instructions serialise the front end through a small FSM instead of
// stall flags: once a branch/jump is accepted no further instruction is
// taken until br_resolve.
// Optional feature: define MEM_SERIALIZE_EN to also serialise LW/SW,
// releasing on mem_done. Without it loads/stores flow freely and
// mem_done is ignored.
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready/in_inst/in_pc   fetch side handshake
//   out_valid/out_ready/out_uop       issue side handshake (head of FIFO)
//   flush                             drop all buffered uops, FSM -> RUN
//   br_resolve                        outstanding branch/jump resolved
//   mem_done                          outstanding LW/SW completed
//   illegal_cnt                       saturating count of illegal uops accepted
module decode_queue
    import decode_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output uop_t             out_uop,
    input  logic             flush,
    input  logic             br_resolve,
    input  logic             mem_done,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] ILL_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] ILL_MAX  = {CNT_W{1'b1}};

    uop_t             fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    state_e           state_q;

    uop_t dec_uop_s;
    logic in_ready_s;
    logic out_valid_s;
    logic push_s;
    logic pop_s;

    decode_comb u_decode_comb (
        .inst_i (in_inst),
        .pc_i   (in_pc),
        .uop_o  (dec_uop_s)
    );

    // Ready depends only on registered state, reset and flush, never on out_ready
    assign in_ready_s  = rst && (count_q < DEPTH_C) && (state_q == ST_RUN) && !flush;
    assign out_valid_s = rst && (count_q != '0);
    assign push_s      = in_valid && in_ready_s;
    assign pop_s       = out_valid_s && out_ready;

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_s;
    assign out_uop     = fifo_q[rd_ptr_q];
    assign illegal_cnt = illegal_cnt_q;

`ifndef MEM_SERIALIZE_EN
    logic unused_mem_done_s;
    assign unused_mem_done_s = mem_done;
`endif

    // Next-state for FIFO pointers, occupancy and illegal counter
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        illegal_cnt_d = illegal_cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // push_s is already gated by flush, so no explicit flush term here
        if (push_s && dec_uop_s.illegal && (illegal_cnt_q != ILL_MAX)) begin
            illegal_cnt_d = illegal_cnt_q + ILL_ONE;
        end else begin
            illegal_cnt_d = illegal_cnt_q;
        end
    end

    // Pointer, occupancy and counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            illegal_cnt_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // Uop storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_q[wr_ptr_q] <= dec_uop_s;
        end
    end

    // Serialisation FSM: blocks fetch after control flow (and optionally memory ops)
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else if (flush) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (push_s && dec_uop_s.branch) begin
                        state_q <= ST_BR_WAIT;
`ifdef MEM_SERIALIZE_EN
                    end else if (push_s && dec_uop_s.mem_access) begin
                        state_q <= ST_MEM_WAIT;
`endif
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_BR_WAIT: begin
                    if (br_resolve) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_BR_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
`ifdef MEM_SERIALIZE_EN
                    if (mem_done) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_MEM_WAIT;
                    end
`else
                    // Unreachable in this build; fall back to RUN if ever entered
                    state_q <= ST_RUN;
`endif
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule
